// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with Mealy flag, programmable pattern, overlap select and saturating match count (optional SEQDET_MASK_EN adds a don't-care mask)
module seq_detector_param #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               in,
    input  logic               in_valid,
    input  logic [PAT_LEN-1:0] pat,
`ifdef SEQDET_MASK_EN
    input  logic [PAT_LEN-1:0] mask,
`endif
    input  logic               ovl,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);
    localparam int FW = $clog2(PAT_LEN);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);
    typedef enum logic [1:0] {EMPTY, FILLING, ARMED} state_t;
    state_t             state;
    logic [PAT_LEN-2:0] hist;
    logic [FW-1:0]      fill, fill_n;
    logic [PAT_LEN-1:0] word, diff;
    assign armed = (state == ARMED);
    // Compare held history plus the bit on the wire; gated until a full window is held
    always_comb begin
        word = {hist, in};
`ifdef SEQDET_MASK_EN
        diff = (word ^ pat) & ~mask;
`else
        diff = word ^ pat;
`endif
        out    = in_valid && armed && diff == '0;
        fill_n = (fill == FULL) ? FULL : fill + FW'(1);
    end
    // Shift history, track fill level and state, count matches without wrapping
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hist      <= '0;
            fill      <= '0;
            state     <= EMPTY;
            match_cnt <= '0;
        end else if (in_valid) begin
            if (out && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
            if (out && !ovl) begin
                hist  <= '0;
                fill  <= '0;
                state <= EMPTY;
            end else begin
                hist  <= word[PAT_LEN-2:0];
                fill  <= fill_n;
                state <= (fill_n == FULL) ? ARMED : FILLING;
            end
        end
    end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: random and directed check of two detector instances against a queue-based model
module tb_seq_detector_param;
    logic clk = 0, clr = 1, in = 0, in_valid = 0, ovl = 1;
    logic [3:0] pat4 = 4'b1111, mask4 = 4'b0000;
    logic [2:0] pat3 = 3'b010, mask3 = 3'b000;
    logic out4, armed4, out3, armed3;
    logic [1:0] cnt4;
    logic [7:0] cnt3;
    int compared = 0, mismatched = 0;
    bit q4[$], q3[$];
    int mc4 = 0, mc3 = 0;
    bit h4, h3;
    int e6[10] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3};

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_LEN(4), .CNT_W(2)) u4 (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid), .pat(pat4),
`ifdef SEQDET_MASK_EN
        .mask(mask4),
`endif
        .ovl(ovl), .out(out4), .match_cnt(cnt4), .armed(armed4));

    seq_detector_param #(.PAT_LEN(3), .CNT_W(8)) u3 (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid), .pat(pat3),
`ifdef SEQDET_MASK_EN
        .mask(mask3),
`endif
        .ovl(ovl), .out(out3), .match_cnt(cnt3), .armed(armed3));

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, a, e, $time);
        end
    endtask

    // last L-1 held bits plus the current bit against the pattern, oldest bit first
    function automatic bit hit(input bit q[$], input int L, input logic [31:0] p,
                               input logic [31:0] mk, input logic b);
        int s = q.size();
        if (s < L - 1) return 1'b0;
        for (int i = 0; i < L - 1; i++)
            if (!mk[L-1-i] && q[s-(L-1)+i] != p[L-1-i]) return 1'b0;
        return mk[0] || b == p[0];
    endfunction

    always @(negedge clk) begin
        if (clr) begin
            q4.delete(); q3.delete(); mc4 = 0; mc3 = 0;
        end
        h4 = !clr && in_valid && hit(q4, 4, 32'(pat4), 32'(mask4), in);
        h3 = !clr && in_valid && hit(q3, 3, 32'(pat3), 32'(mask3), in);
        chk("m_out4", 32'(out4), 32'(h4));
        chk("m_armed4", 32'(armed4), 32'(q4.size() == 3));
        chk("m_cnt4", 32'(cnt4), mc4);
        chk("m_out3", 32'(out3), 32'(h3));
        chk("m_armed3", 32'(armed3), 32'(q3.size() == 2));
        chk("m_cnt3", 32'(cnt3), mc3);
        if (!clr && in_valid) begin
            if (h4 && mc4 < 3) mc4++;
            if (h3 && mc3 < 255) mc3++;
            if (h4 && !ovl) q4.delete();
            else begin
                q4.push_back(in);
                if (q4.size() > 3) void'(q4.pop_front());
            end
            if (h3 && !ovl) q3.delete();
            else begin
                q3.push_back(in);
                if (q3.size() > 2) void'(q3.pop_front());
            end
        end
    end

    task automatic step(input logic b, input logic v);
        @(posedge clk); #1;
        in = b; in_valid = v;
        #2;
    endtask

    task automatic do_clr();
        @(posedge clk); #1;
        clr = 1; in_valid = 0;
        @(posedge clk); #1;
        clr = 0;
    endtask

    task automatic run(input logic [15:0] bits, input int n, input logic c4, input logic [15:0] e4,
                       input logic c3, input logic [15:0] e3);
        for (int i = 0; i < n; i++) begin
            step(bits[n-1-i], 1'b1);
            if (c4) chk($sformatf("d_out4_bit%0d", i + 1), 32'(out4), 32'(e4[n-1-i]));
            if (c3) chk($sformatf("d_out3_bit%0d", i + 1), 32'(out3), 32'(e3[n-1-i]));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 clr = 0;
        ovl = 1; pat4 = 4'b1111;
        run(16'b01111110, 8, 1, 16'b00001110, 0, 0);
        step(0, 0);
        chk("t1_cnt", 32'(cnt4), 3);
        do_clr(); ovl = 0;
        run(16'b0111111, 7, 1, 16'b0000100, 0, 0);
        step(0, 0);
        chk("t2_armed", 32'(armed4), 0);
        chk("t2_cnt", 32'(cnt4), 1);
        do_clr(); ovl = 0; pat3 = 3'b010;
        run(16'b010100, 6, 0, 0, 1, 16'b001000);
        do_clr(); ovl = 1;
        run(16'b010100, 6, 0, 0, 1, 16'b001010);
        do_clr(); ovl = 1; pat4 = 4'b1111;
        run(16'b111, 3, 1, 16'b000, 0, 0);
        do_clr();
        step(1, 1);
        chk("t4_out", 32'(out4), 0);
        chk("t4_armed", 32'(armed4), 0);
        chk("t4_cnt", 32'(cnt4), 0);
        run(16'b111, 3, 1, 16'b001, 0, 0);
        do_clr(); pat4 = 4'b0000;
        run(16'b000, 3, 1, 16'b000, 0, 0);
        step(0, 0);
        chk("t5_armed", 32'(armed4), 1);
        run(16'b0, 1, 1, 16'b1, 0, 0);
        step(1, 1); step(0, 0); step(0, 0); step(1, 1);
        do_clr(); pat4 = 4'b1111; ovl = 1;
        for (int i = 0; i < 10; i++) begin
            step(1, 1);
            chk($sformatf("t6_cnt_bit%0d", i + 1), 32'(cnt4), e6[i]);
        end
        step(0, 0);
        chk("t6_cnt_hold", 32'(cnt4), 3);
`ifdef SEQDET_MASK_EN
        do_clr(); mask4 = 4'b0110; pat4 = 4'b1001;
        run(16'b1011, 4, 1, 16'b0001, 0, 0);
        mask4 = 4'b0000;
`endif
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            clr = ($urandom_range(0, 149) == 0);
            in = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) ovl = 1'($urandom);
            if ($urandom_range(0, 99) == 0) pat4 = 4'($urandom);
            if ($urandom_range(0, 99) == 0) pat3 = 3'($urandom);
`ifdef SEQDET_MASK_EN
            if ($urandom_range(0, 99) == 0) mask4 = 4'($urandom & $urandom);
            if ($urandom_range(0, 99) == 0) mask3 = 3'($urandom & $urandom);
`endif
        end
        @(posedge clk); #1;
        clr = 0; in_valid = 0;
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector with Mealy output. It generalises the fixed-pattern 010/1111 detectors to:
- any pattern length;
- a runtime-programmable pattern;
- runtime selection of overlapping or non-overlapping detection;
- an input-valid qualifier;
- a saturating match counter.

It sits on a serial input stream and flags each pattern completion in the same cycle as the final bit.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..32.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
clr  input  1  asynchronous active-high reset.
in  input  1  serial data bit.
in_valid  input  1  qualifies `in`; when low, no state changes and `out` is 0.
pat  input  PAT_LEN  pattern; pat[PAT_LEN-1] is the first bit received, pat[0] the last.
ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
out  output  1  Mealy match flag, combinational from current state, `in` and `pat`.
match_cnt  output  CNT_W  registered count of matches, saturating.
armed  output  1  registered; 1 when at least PAT_LEN-1 valid bits are held since the last clear or restart.

Behaviour:
- Reset: clr=1 asynchronously clears all state:
  - hist = 0 (PAT_LEN-1 bits);
  - fill = 0;
  - match_cnt = 0;
  - armed = 0;
  - out = 0 while clr=1.
- hist: shift register of the last PAT_LEN-1 valid bits. hist[0] is the newest bit.
- fill: counts valid bits held, saturating at PAT_LEN-1.
- States are encoded by fill:
  - EMPTY: fill=0.
  - FILLING: 0 < fill < PAT_LEN-1.
  - ARMED: fill = PAT_LEN-1. The `armed` output equals (fill==PAT_LEN-1).
- Match (combinational): `out` = in_valid & armed & ({hist, in} == pat).
  - Zero latency: `out` is high in the cycle the last pattern bit is presented, before the clock edge.
- On a rising edge with in_valid=1 and no match:
  - hist shifts left and takes in `in`;
  - fill increments, saturating at PAT_LEN-1.
- On a rising edge with in_valid=1 and a match:
  - match_cnt increments, saturating at all-ones; there is no wrap.
  - If ovl=1: hist shifts in `in` as normal and fill stays at PAT_LEN-1. A suffix of the match can therefore begin the next match (e.g. 1111 on six 1s gives 3 matches).
  - If ovl=0: hist is cleared to 0 and fill goes to 0 (EMPTY). The next match needs PAT_LEN fresh bits.
- in_valid=0: hist, fill and match_cnt all hold, and `out` = 0. Gaps of any length are transparent to the detection.
- Before ARMED, no match is possible, even if zero-initialised hist bits would compare equal. This prevents false hits on all-zero patterns after reset.
- `pat` and `ovl` changes take effect immediately in the compare and on the next edge. Already-held history is kept and is not re-evaluated retroactively.
- Reset mid-stream: partial progress is lost. Detection restarts from EMPTY on the first valid bit after clr falls.
- Asynchronous clr assertion coincident with a match: the counter does not increment, and reset wins.

Optional Feature:
Macro SEQDET_MASK_EN.
- Defined:
  - adds input port `mask` (PAT_LEN bits);
  - bit positions with mask=1 are don't-care in the compare, so `out` = in_valid & armed & ((({hist,in} ^ pat) & ~mask) == 0);
  - all other behaviour is unchanged;
  - mask=all-ones matches every armed valid bit.
- Not defined:
  - no `mask` port exists;
  - the compare is an exact equality as above.

Test Plan:
1. PAT_LEN=4, pat=4'b1111, ovl=1, in_valid=1, stream 0,1,1,1,1,1,1,0 -> out=1 on the 5th, 6th and 7th bits; match_cnt=3 after the stream.
2. Same stream with ovl=0 -> out=1 on the 5th bit only; match_cnt=1; fill=2 after the 7th bit.
3. PAT_LEN=3, pat=3'b010, ovl=0, stream 0,1,0,1,0,0 -> out=1 on the 3rd bit only; with ovl=1 -> out=1 on the 3rd and 5th bits.
4. PAT_LEN=4, pat=4'b1111, ovl=1, stream 1,1,1, then clr pulse, then 1 -> out stays 0, armed=0, match_cnt=0. A further 1,1,1 -> out=1 on the 4th post-reset bit.
5. pat=4'b0000, stream 0,0,0 immediately after reset -> out=0, armed=1 after the 3rd bit, and out=1 on the 4th 0.
   - Then 1,1 with in_valid=0 in between -> hist unchanged across the gap.
6. CNT_W=2, pat=4'b1111, ovl=1, ten consecutive 1s -> match_cnt goes 1,2,3,3,...; holds at 3 with no wrap.
   - With SEQDET_MASK_EN and mask=4'b0110, pat=4'b1001, stream 1,0,1,1 -> out=1 on the 4th bit.
